// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, error codes and SOF default for the UART receive path
package uart_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CKSUM   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CKSUM   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_byte_strobe.sv
// rtl/uart_byte_strobe.sv - RxDone rising-edge detector with captured byte, one strobe per byte
module uart_byte_strobe (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  output logic       strobe_o,
  output logic [7:0] data_o
);

  logic       done_q;
  logic [7:0] data_q;

  // Edge register starts high so a receiver already holding done at reset release is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b1;
      data_q <= 8'h00;
    end else begin
      done_q <= rx_done_i;
      if (strobe_o) begin
        data_q <= rx_data_i;
      end
    end
  end

  assign strobe_o = rx_done_i & ~done_q;
  assign data_o   = strobe_o ? rx_data_i : data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/LEN/payload frame parser on the RS232 receive byte stream
// Trailing checksum byte and CKSUM state are built only when UART_PARSER_CKSUM_EN is defined.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int          MAX_LEN = 16,
  parameter logic [7:0]  SOF     = SOF_DEFAULT,
  parameter logic [31:0] TIMEOUT = 32'd500000,
  parameter int          LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [7:0]    RxData,
  input  logic          RxDone,
  output logic [7:0]    PayloadData,
  output logic          PayloadValid,
  output logic          FrameDone,
  output logic          FrameErr,
  output logic [1:0]    ErrCode,
  output logic [LW-1:0] FrameLen,
  output logic          Busy
);

  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [31:0] TMO_LAST  = TIMEOUT - 32'd1;

  logic       byte_stb;
  logic [7:0] byte_data;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [31:0]   tmo_q, tmo_d;

  logic [7:0]    payload_data_q, payload_data_d;
  logic          payload_valid_q, payload_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [LW-1:0] frame_len_q, frame_len_d;

  logic len_bad;
  logic last_byte;
  logic timeout_hit;

`ifdef UART_PARSER_CKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  uart_byte_strobe u_strobe (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .rx_data_i (RxData),
    .rx_done_i (RxDone),
    .strobe_o  (byte_stb),
    .data_o    (byte_data)
  );

  assign len_bad   = (byte_data == 8'h00) || (byte_data > MAX_LEN_B);
  assign last_byte = (rem_q == LW'(1));
  // An accepted byte in the expiring cycle takes priority over the timeout.
  assign timeout_hit = (state_q != ST_HUNT) && (tmo_q == TMO_LAST) && !byte_stb;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = ST_HUNT;
    end else if (byte_stb) begin
      case (state_q)
        ST_HUNT:    if (byte_data == SOF) state_d = ST_LEN;
        ST_LEN:     state_d = len_bad ? ST_HUNT : ST_PAYLOAD;
        ST_PAYLOAD: begin
          if (last_byte) begin
`ifdef UART_PARSER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_HUNT;
`endif
          end
        end
        default:    state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    payload_data_d  = payload_data_q;
    payload_valid_d = 1'b0;
    frame_done_d    = 1'b0;
    frame_err_d     = 1'b0;
    err_code_d      = err_code_q;
    frame_len_d     = frame_len_q;
    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      frame_len_d = (state_q == ST_LEN) ? '0 : len_q;
    end else if (byte_stb) begin
      case (state_q)
        ST_LEN: begin
          if (len_bad) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            frame_len_d = '0;
          end
        end
        ST_PAYLOAD: begin
          payload_valid_d = 1'b1;
          payload_data_d  = byte_data;
`ifndef UART_PARSER_CKSUM_EN
          if (last_byte) begin
            frame_done_d = 1'b1;
            err_code_d   = ERR_NONE;
            frame_len_d  = len_q;
          end
`endif
        end
`ifdef UART_PARSER_CKSUM_EN
        ST_CKSUM: begin
          frame_len_d = len_q;
          if (byte_data == sum_q) begin
            frame_done_d = 1'b1;
            err_code_d   = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CKSUM;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    len_d = len_q;
    rem_d = rem_q;
    tmo_d = tmo_q + 32'd1;
`ifdef UART_PARSER_CKSUM_EN
    sum_d = sum_q;
`endif
    if (state_q == ST_HUNT || byte_stb) begin
      tmo_d = 32'd0;
    end
    if (byte_stb && !timeout_hit) begin
      case (state_q)
        ST_HUNT: begin
`ifdef UART_PARSER_CKSUM_EN
          if (byte_data == SOF) sum_d = 8'h00;
`endif
        end
        ST_LEN: begin
          if (!len_bad) begin
            len_d = byte_data[LW-1:0];
            rem_d = byte_data[LW-1:0];
`ifdef UART_PARSER_CKSUM_EN
            sum_d = byte_data;
`endif
          end
        end
        ST_PAYLOAD: begin
          rem_d = rem_q - LW'(1);
`ifdef UART_PARSER_CKSUM_EN
          sum_d = sum_q + byte_data;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      len_q <= '0;
      rem_q <= '0;
      tmo_q <= 32'd0;
`ifdef UART_PARSER_CKSUM_EN
      sum_q <= 8'h00;
`endif
      payload_data_q  <= 8'h00;
      payload_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      err_code_q      <= ERR_NONE;
      frame_len_q     <= '0;
    end else begin
      len_q <= len_d;
      rem_q <= rem_d;
      tmo_q <= tmo_d;
`ifdef UART_PARSER_CKSUM_EN
      sum_q <= sum_d;
`endif
      payload_data_q  <= payload_data_d;
      payload_valid_q <= payload_valid_d;
      frame_done_q    <= frame_done_d;
      frame_err_q     <= frame_err_d;
      err_code_q      <= err_code_d;
      frame_len_q     <= frame_len_d;
    end
  end

  assign PayloadData  = payload_data_q;
  assign PayloadValid = payload_valid_q;
  assign FrameDone    = frame_done_q;
  assign FrameErr     = frame_err_q;
  assign ErrCode      = err_code_q;
  assign FrameLen     = frame_len_q;
  assign Busy         = (state_q != ST_HUNT);

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser (adapts to UART_PARSER_CKSUM_EN)
module tb_uart_frame_parser;

  localparam int          MAX_LEN = 16;
  localparam logic [31:0] TIMEOUT = 32'd60;
  localparam int          LW      = 5;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [7:0]    RxData = 8'h00;
  logic          RxDone = 1'b0;
  logic [7:0]    PayloadData;
  logic          PayloadValid;
  logic          FrameDone;
  logic          FrameErr;
  logic [1:0]    ErrCode;
  logic [LW-1:0] FrameLen;
  logic          Busy;

  uart_frame_parser #(
    .MAX_LEN (MAX_LEN),
    .SOF     (8'hAA),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .RxData       (RxData),
    .RxDone       (RxDone),
    .PayloadData  (PayloadData),
    .PayloadValid (PayloadValid),
    .FrameDone    (FrameDone),
    .FrameErr     (FrameErr),
    .ErrCode      (ErrCode),
    .FrameLen     (FrameLen),
    .Busy         (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0]    kind;
    logic [7:0]    data;
    logic [1:0]    code;
    logic [LW-1:0] len;
  } ev_t;

  localparam logic [1:0] K_PAY = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  pv_cyc = 0;
  int  tmo_cyc = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic exp_pay(input logic [7:0] d);
    exp_q.push_back('{kind: K_PAY, data: d, code: 2'd0, len: '0});
  endtask

  task automatic exp_done(input logic [LW-1:0] l);
    exp_q.push_back('{kind: K_DONE, data: 8'h00, code: 2'd0, len: l});
  endtask

  task automatic exp_err(input logic [1:0] c, input logic [LW-1:0] l);
    exp_q.push_back('{kind: K_ERR, data: 8'h00, code: c, len: l});
  endtask

  task automatic pop_cmp(input logic [1:0] kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL unexpected_output: got kind %0d expected none", kind);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    case (kind)
      K_PAY:   chk("payload_data", 32'(PayloadData), 32'(e.data));
      K_DONE: begin
        chk("done_len", 32'(FrameLen), 32'(e.len));
        chk("done_code", 32'(ErrCode), 32'(e.code));
      end
      default: begin
        chk("err_code", 32'(ErrCode), 32'(e.code));
        chk("err_len", 32'(FrameLen), 32'(e.len));
      end
    endcase
  endtask

  initial begin : monitor
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (PayloadValid || FrameDone || FrameErr) begin
        chk("done_err_exclusive", 32'(FrameDone & FrameErr), 32'd0);
        if (PayloadValid) begin
          pv_cyc = cyc;
          pop_cmp(K_PAY);
        end
        if (FrameDone) pop_cmp(K_DONE);
        if (FrameErr) begin
          if (ErrCode == 2'd3) tmo_cyc = cyc;
          pop_cmp(K_ERR);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge Clk);
    RxData = b;
    RxDone = 1'b1;
    repeat (hold) @(negedge Clk);
    RxDone = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pdata"}, 32'(PayloadData), 32'h00);
    chk({tag, "_pvalid"}, 32'(PayloadValid), 32'd0);
    chk({tag, "_done"}, 32'(FrameDone), 32'd0);
    chk({tag, "_err"}, 32'(FrameErr), 32'd0);
    chk({tag, "_code"}, 32'(ErrCode), 32'd0);
    chk({tag, "_len"}, 32'(FrameLen), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  initial begin : stimulus
    // Receiver holds RxDone high across reset release: must not yield a byte.
    RxData = 8'hAA;
    RxDone = 1'b1;
    repeat (3) @(negedge Clk);
    chk_reset("reset");
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    RxDone = 1'b0;
    repeat (2) @(negedge Clk);
    chk("held_done_busy", 32'(Busy), 32'd0);

    // Basic three-byte frame
    exp_pay(8'h11); exp_pay(8'h22); exp_pay(8'h33); exp_done(5'd3);
    send_byte(8'hAA, 1); send_byte(8'h03, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
`ifdef UART_PARSER_CKSUM_EN
    send_byte(8'h69, 1);
    exp_pay(8'h11); exp_pay(8'h22); exp_pay(8'h33); exp_err(2'd2, 5'd3);
    send_byte(8'hAA, 1); send_byte(8'h03, 1);
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
    send_byte(8'h67, 1);
`endif

    // Junk in HUNT, then LEN = 0
    exp_err(2'd1, 5'd0);
    send_byte(8'h55, 1); send_byte(8'h00, 1); send_byte(8'hAA, 1); send_byte(8'h00, 1);

    // LEN one above MAX_LEN
    exp_err(2'd1, 5'd0);
    send_byte(8'hAA, 1); send_byte(8'h11, 1);

    // LEN exactly MAX_LEN
    for (int i = 0; i < MAX_LEN; i++) exp_pay(8'(i));
    exp_done(5'd16);
    send_byte(8'hAA, 1); send_byte(8'h10, 1);
    for (int i = 0; i < MAX_LEN; i++) send_byte(8'(i), 1);
`ifdef UART_PARSER_CKSUM_EN
    send_byte(8'h88, 1);
`endif

    // Inter-byte timeout
    tmo_cyc = -1;
    exp_pay(8'h41); exp_err(2'd3, 5'd2);
    send_byte(8'hAA, 1); send_byte(8'h02, 1); send_byte(8'h41, 1);
    chk("busy_midframe", 32'(Busy), 32'd1);
    repeat (int'(TIMEOUT) + 5) @(negedge Clk);
    chk("timeout_delay", 32'(tmo_cyc - pv_cyc), TIMEOUT);
    chk("busy_after_timeout", 32'(Busy), 32'd0);

    // Long RxDone levels; payload byte equals SOF
    exp_pay(8'hAA); exp_done(5'd1);
    send_byte(8'hAA, 40); send_byte(8'h01, 40); send_byte(8'hAA, 40);
`ifdef UART_PARSER_CKSUM_EN
    send_byte(8'hAB, 40);
`else
    send_byte(8'h01, 40);
`endif
    chk("busy_after_long", 32'(Busy), 32'd0);

    // Reset mid-frame, then a clean frame
    exp_pay(8'h11);
    send_byte(8'hAA, 1); send_byte(8'h04, 1); send_byte(8'h11, 1);
    chk("busy_before_reset", 32'(Busy), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    exp_pay(8'h5A); exp_pay(8'h5B); exp_done(5'd2);
    send_byte(8'hAA, 1); send_byte(8'h02, 1); send_byte(8'h5A, 1); send_byte(8'h5B, 1);
`ifdef UART_PARSER_CKSUM_EN
    send_byte(8'hB7, 1);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge Clk);
    repeat (5) @(negedge Clk);
    chk("events_left", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
